// File: rtl/rep3_tx_pkg.sv
// Shared types and line levels for the triple-repetition serial transmitter.
// Optional parity symbol is enabled by defining REP3_TX_PARITY_EN.
package rep3_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/rep_symbol_timer.sv
// Counts the REP cycles of each line symbol; sym_tick marks the last cycle of a symbol.
// sym_pre_tick marks the cycle before it so the caller can register an end-of-symbol flag.
module rep_symbol_timer #(
   parameter int REP = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sym_tick,
   output logic sym_pre_tick
);

   localparam int CW = $clog2(REP);
   localparam logic [CW-1:0] LAST_CNT = CW'(REP - 1);
   localparam logic [CW-1:0] PRE_CNT  = CW'(REP - 2);

   logic [CW-1:0] rep_cnt_q;
   logic [CW-1:0] rep_cnt_d;

   assign sym_tick     = run && (rep_cnt_q == LAST_CNT);
   assign sym_pre_tick = run && (rep_cnt_q == PRE_CNT);

   // Held at zero while idle so the first symbol of a frame gets its full REP cycles.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      if (!run) begin
         rep_cnt_d = '0;
      end else if (sym_tick) begin
         rep_cnt_d = '0;
      end else begin
         rep_cnt_d = rep_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end

endmodule

// File: rtl/rep3_serial_tx.sv
// Serial transmitter: start, data LSB first, optional even parity, stop; each symbol held REP cycles.
// Define REP3_TX_PARITY_EN to insert the parity symbol between the data bits and the stop symbol.
module rep3_serial_tx
   import rep3_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REP    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_en,
   output logic              busy,
   output logic              done
);

   localparam int BW = $clog2(DATA_W) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_t         state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_shift;
   logic [BW-1:0]     bit_cnt_q;
   logic              tx_bit_q;
   logic              tx_en_q;
   logic              busy_q;
   logic              done_q;
`ifdef REP3_TX_PARITY_EN
   logic              parity_q;
`endif

   logic run;
   logic accept;
   logic sym_tick;
   logic sym_pre_tick;

   assign run         = (state_q != IDLE);
   assign in_ready    = (state_q == IDLE) && rst_n;
   assign accept      = in_valid && in_ready;
   assign shreg_shift = shreg_q >> 1;

   assign tx_bit = tx_bit_q;
   assign tx_en  = tx_en_q;
   assign busy   = busy_q;
   assign done   = done_q;

   rep_symbol_timer #(
      .REP (REP)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .sym_tick     (sym_tick),
      .sym_pre_tick (sym_pre_tick)
   );

   // Line outputs are loaded with the level of the symbol being entered, so they change
   // on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tx_bit_q  <= LINE_IDLE;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef REP3_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q   <= in_data;
                  bit_cnt_q <= '0;
`ifdef REP3_TX_PARITY_EN
                  parity_q  <= ^in_data;
`endif
                  state_q   <= START;
                  tx_bit_q  <= START_LVL;
                  tx_en_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (sym_tick) begin
                  state_q  <= DATA;
                  tx_bit_q <= shreg_q[0];
               end
            end
            DATA: begin
               if (sym_tick) begin
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef REP3_TX_PARITY_EN
                     state_q  <= PARITY;
                     tx_bit_q <= parity_q;
`else
                     state_q  <= STOP;
                     tx_bit_q <= STOP_LVL;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                     shreg_q   <= shreg_shift;
                     tx_bit_q  <= shreg_shift[0];
                  end
               end
            end
`ifdef REP3_TX_PARITY_EN
            PARITY: begin
               if (sym_tick) begin
                  state_q  <= STOP;
                  tx_bit_q <= STOP_LVL;
               end
            end
`endif
            STOP: begin
               // done is registered, so it is raised one cycle ahead of the final stop cycle.
               if (sym_pre_tick) begin
                  done_q <= 1'b1;
               end
               if (sym_tick) begin
                  state_q  <= IDLE;
                  tx_bit_q <= LINE_IDLE;
                  tx_en_q  <= 1'b0;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               tx_bit_q <= LINE_IDLE;
               tx_en_q  <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule
